// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the sequential IEEE-754 adder/subtractor.
package fp_pkg;

    // Default field widths (IEEE-754 single precision) and exponent bias
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    // Canonical quiet NaN produced for invalid operations such as inf - inf
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Classification: an all-ones exponent field marks inf (fraction 0) or NaN (fraction != 0);
    // the fraction MSB is the quiet bit of a NaN
    localparam logic [FP_EXP_W-1:0] FP_EXP_SPECIAL = '1;
    localparam logic [FP_MAN_W-1:0] FP_QUIET_BIT   = 23'h40_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADD    = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/fp_round.sv
// Combinational round-to-nearest-even with overflow to signed infinity.
// mant_i is {hidden, fraction, guard, round, sticky}; exp_i is the biased exponent (>= 1).
module fp_round
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                   sign_i,
    input  logic [EXP_W+1:0]       exp_i,
    input  logic [MAN_W+3:0]       mant_i,
    output logic [EXP_W+MAN_W:0]   res_o
);

    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
    localparam logic [EW-1:0]    EXP_INF  = {2'b00, EXP_ALL1};

    logic               lsb;
    logic               guard;
    logic               rest;
    logic               inc;
    logic [MAN_W+1:0]   m_r;
    logic [EW-1:0]      exp_r;
    logic [EW-1:0]      field;
    logic [MAN_W-1:0]   frac;
    logic               hidden;

    // Round the kept mantissa, renormalise on carry, then map the exponent to its field value
    always_comb begin
        lsb    = mant_i[3];
        guard  = mant_i[2];
        rest   = mant_i[1] | mant_i[0];
        inc    = guard & (rest | lsb);
        m_r    = {1'b0, mant_i[MAN_W+3:3]} + (MAN_W+2)'(inc);
        exp_r  = exp_i;
        frac   = m_r[MAN_W-1:0];
        hidden = m_r[MAN_W];
        if (m_r[MAN_W+1]) begin
            // 1.111..1 rounded up to 10.000..0: fraction becomes zero, exponent bumps
            exp_r  = exp_i + EW'(1);
            frac   = '0;
            hidden = 1'b1;
        end
        // Hidden bit clear means a subnormal result, whose exponent field is zero
        field = hidden ? exp_r : '0;
        if (field >= EXP_INF) begin
            res_o = {sign_i, EXP_ALL1, {MAN_W{1'b0}}};
        end else begin
            res_o = {sign_i, field[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 adder/subtractor: one bit of alignment or normalisation per cycle.
// Operands are captured at acceptance; the datapath then works only on the captured copy.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] add1,
    input  logic [EXP_W+MAN_W:0] add2,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] sum
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;          // hidden + fraction + guard + round + sticky
    localparam int EW = EXP_W + 2;          // headroom for exponent increments

    localparam logic [EW-1:0]    EXP_ONE   = EW'(1);
    localparam logic [EW-1:0]    ALIGN_MAX = EW'(MW - 1);
    localparam logic [EXP_W-1:0] EXP_ALL1  = '1;
    localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ALL1, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0]     QUIET     = W'(1) << (MAN_W - 1);

    state_t            state_q, state_d;
    logic [W-1:0]      opa_q, opa_d;
    logic [W-1:0]      opb_q, opb_d;
    logic              sub_q, sub_d;
    logic              sa_q, sa_d;          // sign of the larger operand (result sign)
    logic              sb_q, sb_d;          // effective sign of the smaller operand
    logic [EW-1:0]     exp_q, exp_d;
    logic [EW-1:0]     diff_q, diff_d;
    logic [MW-1:0]     ma_q, ma_d;
    logic [MW-1:0]     mb_q, mb_d;
    logic [MW:0]       sm_q, sm_d;          // magnitude sum with carry bit on top
    logic [W-1:0]      sum_q, sum_d;

    logic [EXP_W-1:0]  ea_f, eb_f, big_ef, small_ef;
    logic [MAN_W-1:0]  fa, fb, big_f, small_f;
    logic              sa_raw, sb_eff;
    logic              a_nan, b_nan, a_inf, b_inf;
    logic              swap;
    logic [EW-1:0]     big_e, small_e;
    logic [MW:0]       mag_res;
    logic [W-1:0]      rnd_res;

    // Field extraction, classification and magnitude ordering of the captured operands
    always_comb begin
        ea_f    = opa_q[W-2:MAN_W];
        eb_f    = opb_q[W-2:MAN_W];
        fa      = opa_q[MAN_W-1:0];
        fb      = opb_q[MAN_W-1:0];
        sa_raw  = opa_q[W-1];
        sb_eff  = opb_q[W-1] ^ sub_q;
        a_nan   = (ea_f == EXP_ALL1) && (fa != '0);
        b_nan   = (eb_f == EXP_ALL1) && (fb != '0);
        a_inf   = (ea_f == EXP_ALL1) && (fa == '0);
        b_inf   = (eb_f == EXP_ALL1) && (fb == '0);
        swap    = opb_q[W-2:0] > opa_q[W-2:0];
        big_ef   = swap ? eb_f : ea_f;
        small_ef = swap ? ea_f : eb_f;
        big_f    = swap ? fb : fa;
        small_f  = swap ? fa : fb;
        // A zero exponent field behaves as exponent 1 with no hidden bit
        big_e    = (big_ef == '0)   ? EXP_ONE : {2'b00, big_ef};
        small_e  = (small_ef == '0) ? EXP_ONE : {2'b00, small_ef};
    end

    // Add or subtract the aligned magnitudes; |A| >= |B| so subtraction never goes negative
    always_comb begin
        if (sa_q == sb_q) begin
            mag_res = {1'b0, ma_q} + {1'b0, mb_q};
        end else begin
            mag_res = {1'b0, ma_q} - {1'b0, mb_q};
        end
    end

    fp_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign_i (sa_q),
        .exp_i  (exp_q),
        .mant_i (sm_q[MW-1:0]),
        .res_o  (rnd_res)
    );

    // Next-state and datapath update for each FSM step
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sub_d   = sub_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        exp_d   = exp_q;
        diff_d  = diff_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sm_d    = sm_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opa_d   = add1;
                    opb_d   = add2;
                    sub_d   = sub;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (a_nan) begin
                    sum_d   = opa_q | QUIET;
                    state_d = S_DONE;
                end else if (b_nan) begin
                    sum_d   = opb_q | QUIET;
                    state_d = S_DONE;
                end else if (a_inf && b_inf && (sa_raw != sb_eff)) begin
                    sum_d   = QNAN;
                    state_d = S_DONE;
                end else if (a_inf) begin
                    sum_d   = {sa_raw, opa_q[W-2:0]};
                    state_d = S_DONE;
                end else if (b_inf) begin
                    sum_d   = {sb_eff, opb_q[W-2:0]};
                    state_d = S_DONE;
                end else begin
                    sa_d    = swap ? sb_eff : sa_raw;
                    sb_d    = swap ? sa_raw : sb_eff;
                    exp_d   = big_e;
                    diff_d  = big_e - small_e;
                    ma_d    = {(big_ef != '0), big_f, 3'b000};
                    mb_d    = {(small_ef != '0), small_f, 3'b000};
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (diff_q == '0) begin
                    state_d = S_ADD;
                end else if (diff_q > ALIGN_MAX) begin
                    // Everything would shift out: fold it all into sticky at once
                    mb_d   = {{(MW-1){1'b0}}, |mb_q};
                    diff_d = '0;
                end else begin
                    mb_d   = {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
                    diff_d = diff_q - EW'(1);
                    if (diff_q == EXP_ONE) begin
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                if (mag_res == '0) begin
                    // Exact zero is +0 unless both contributions were negative
                    sum_d   = {(sa_q & sb_q), {(W-1){1'b0}}};
                    state_d = S_DONE;
                end else begin
                    sm_d    = mag_res;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (sm_q[MW]) begin
                    sm_d    = {1'b0, sm_q[MW:2], sm_q[1] | sm_q[0]};
                    exp_d   = exp_q + EW'(1);
                    state_d = S_ROUND;
                end else if (sm_q[MW-1] || (exp_q == EXP_ONE)) begin
                    state_d = S_ROUND;
                end else begin
                    sm_d  = sm_q << 1;
                    exp_d = exp_q - EW'(1);
                end
            end
            S_ROUND: begin
                sum_d   = rnd_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and abandons any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sub_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            exp_q   <= '0;
            diff_q  <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sm_q    <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sub_q   <= sub_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            exp_q   <= exp_d;
            diff_q  <= diff_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sm_q    <= sm_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;

endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width (total word width = 1+EXP_W+MAN_W = 32).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair and sub are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port add1  input  32  IEEE-754 single operand A.
REQ-008 SHALL have port add2  input  32  IEEE-754 single operand B.
REQ-009 SHALL have port sub  input  1  0: A+B, 1: A-B.
REQ-010 SHALL have port out_valid  output  1  sum holds a completed result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts sum.
REQ-012 SHALL have port sum  output  32  IEEE-754 single result.

Function
REQ-013 SHALL accept operands when in_valid and in_ready are both high on a clock edge, and capture add1, add2 and sub on that edge.
REQ-014 SHALL implement FSM IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 UNPACK (1 cycle): exponent field 0 treated as exponent 1 with hidden bit 0; operands swapped so |A|>=|B|; effective sign of B = sign(B) xor sub; diff = expA-expB.
REQ-016 UNPACK special cases go directly to DONE: any NaN -> that NaN with quiet bit set (A's if both NaN); inf+(-inf) effective -> 0x7FC00000; one inf -> that inf with effective sign.
REQ-017 ALIGN: shift B right 1 bit per cycle, decrementing diff, OR-ing shifted-out bits into sticky; if diff>26, clear B mantissa into sticky in one cycle; exit when diff=0.
REQ-018 ADD (1 cycle): add magnitudes if signs equal, else subtract; zero magnitude -> DONE with +0, except -0 when both effective signs negative.
REQ-019 NORM: carry-out -> one right shift, exp+1; else shift left 1 bit per cycle, exp-1, until hidden bit set or exp=1 (subnormal result, exponent field 0).
REQ-020 ROUND (1 cycle): round-to-nearest-even from guard/round/sticky; mantissa overflow -> exp+1; exponent field >=255 -> signed infinity, mantissa 0.
REQ-021 Latency from acceptance to out_valid SHALL be 2 cycles for special cases and at most 56 cycles otherwise.
REQ-022 DONE SHALL hold sum and out_valid stable until out_ready is high on an edge, then return to IDLE; no new operands accepted that cycle (in_ready rises the following cycle).
REQ-023 Inputs changing while not in IDLE SHALL have no effect on the result in flight.

Reset
REQ-024 rst high SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, and clear all internal registers.
REQ-025 Reset mid-operation SHALL discard the operation in flight; no result is produced for it.

Structure
REQ-026 A shared package fp_pkg SHALL hold EXP_W/MAN_W, bias 127, the FSM state enum, the canonical quiet NaN 0x7FC00000, and the inf/NaN classification constants.
REQ-027 One sub-module fp_round SHALL implement the combinational round-to-nearest-even plus overflow-to-infinity step; everything else stays in fp_addsub_seq.

Verification
REQ-028 add1=0x3FFFFFFF, add2=0x3FFFFFFF, sub=0 -> sum 0x407FFFFF; add1=0xBFFFFFFF, same add2 -> 0x00000000.
REQ-029 add1=0x3E8C0001, add2=0x3F180000 (tie on guard bit) -> 0x3F5E0000; add1=0x000002CA, add2=0x000002CA (subnormals) -> 0x00000594.
REQ-030 add1=0x7F800000, add2=0x42F60000 -> 0x7F800000 after exactly 2 cycles; add1=0x7F800000, add2=0x7F800000, sub=1 -> 0x7FC00000.
REQ-031 add1=0x3F800000, add2=0x3F800000, sub=1 -> 0x00000000; add1=0x7F7FFFFF, add2=0x7F7FFFFF -> 0x7F800000.
REQ-032 out_ready held low 5 cycles in DONE -> sum and out_valid unchanged, in_ready=0; release -> IDLE next cycle.
REQ-033 rst pulsed during ALIGN (add1=0x4B000000, add2=0x3F800000) -> out_valid=0, in_ready=1 immediately; next operation returns the correct result.
